// File: rtl/divider_pkg.sv
// divider_pkg: shared FSM state type and counter-width helper for the restoring divider
package divider_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/divider_sub_step.sv
// divider_sub_step: N-bit ripple borrow-chain subtractor, diff = a - b with borrow-in 0
// Ports:
//   a, b    in   N  minuend, subtrahend
//   diff    out  N  a - b modulo 2^N
//   borrow  out  1  1 when a < b
module divider_sub_step #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] br;

    assign br[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ br[i];
        assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end

    assign borrow = br[N];

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: iterative unsigned restoring divider, one quotient bit per clock
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        operand handshake (dividend, divisor)
//   out_valid/out_ready      result handshake (quotient, remainder, div_by_zero)
// Optional feature: define DIV_ZERO_FAST_EN to resolve divide-by-zero in one clock
// and flag it on div_by_zero; otherwise divide-by-zero runs the normal steps and
// div_by_zero stays 0.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             fit;

    divider_sub_step #(.N(WIDTH + 1)) u_step (
        .a      ({r_q, q_q[WIDTH-1]}),
        .b      ({1'b0, dvs_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    // While R < divisor the trial difference never exceeds WIDTH bits, so the
    // top bit only matters as a guard alongside the borrow.
    assign fit = ~(borrow | trial[WIDTH]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                dvs_d   = divisor;
                q_d     = dividend;
                r_d     = '0;
                dbz_d   = 1'b0;
                cnt_d   = CW'(WIDTH);
                state_d = RUN;
`ifdef DIV_ZERO_FAST_EN
                if (divisor == '0) begin
                    q_d     = '1;
                    r_d     = dividend;
                    dbz_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end
`endif
            end
            RUN: begin
                q_d     = {q_q[WIDTH-2:0], fit};
                r_d     = fit ? trial[WIDTH-1:0] : {r_q[WIDTH-2:0], q_q[WIDTH-1]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? DONE : RUN;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and exhaustive checks of restoring_divider at WIDTH=4
module tb_restoring_divider;

    localparam int W = 4;

`ifdef DIV_ZERO_FAST_EN
    localparam int   ZLAT = 1;
    localparam logic ZDBZ = 1'b1;
`else
    localparam int   ZLAT = 5;
    localparam logic ZDBZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat);
        check("in_ready_before_op", in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        q = quotient;
        r = remainder;
        z = div_by_zero;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] q, r;
        logic         z;
        int           lat;
        logic         seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op(4'd13, 4'd3, q, r, z, lat);
        check("13/3_q", q, 4);
        check("13/3_r", r, 1);
        check("13/3_lat", lat, 5);
        check("13/3_dbz", z, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
        check("idle_held_q", quotient, 4);
        check("idle_held_r", remainder, 1);

        run_op(4'd15, 4'd1, q, r, z, lat);
        check("15/1", {q, r}, {4'd15, 4'd0});
        run_op(4'd3, 4'd9, q, r, z, lat);
        check("3/9", {q, r}, {4'd0, 4'd3});
        run_op(4'd0, 4'd5, q, r, z, lat);
        check("0/5", {q, r}, {4'd0, 4'd0});

        run_op(4'd7, 4'd0, q, r, z, lat);
        check("7/0_q", q, 15);
        check("7/0_r", r, 7);
        check("7/0_dbz", z, ZDBZ);
        check("7/0_lat", lat, ZLAT);

        in_valid = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_valid", out_valid, 1);
        repeat (6) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_q", quotient, 4);
            check("bp_hold_r", remainder, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);

        in_valid = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_dbz", div_by_zero, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen |= out_valid;
        end
        check("abort_no_valid", seen, 0);
        run_op(4'd9, 4'd2, q, r, z, lat);
        check("9/2_after_abort", {q, r}, {4'd4, 4'd1});

        in_valid = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd5;
        tick();
        dividend = 4'd15;
        divisor  = 4'd1;
        check("busy_in_ready", in_ready, 0);
        wait_valid(lat);
        check("busy_lat", lat, 5);
        check("busy_q", quotient, 2);
        check("busy_r", remainder, 2);
        check("done_in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_no_accept", {in_ready, out_valid}, {1'b1, 1'b0});
        tick();
        in_valid = 1'b0;
        check("late_accept_in_ready", in_ready, 0);
        wait_valid(lat);
        check("late_accept_result", {quotient, remainder}, {4'd15, 4'd0});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [W-1:0] eq, er;
                logic         ez;
                eq = (b == 0) ? W'(15) : W'(a / b);
                er = (b == 0) ? W'(a) : W'(a % b);
                ez = (b == 0) ? ZDBZ : 1'b0;
                run_op(W'(a), W'(b), q, r, z, lat);
                check($sformatf("exh_%0d/%0d", a, b), {z, q, r}, {ez, eq, er});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
